// File: rtl/eth_game_rx.sv
// RMII receiver for the game-state link: hunts preamble/SFD, filters on destination MAC
// and publishes the opponent's state. Optional FCS checking is enabled with RX_FCS_CHECK_EN.
module eth_game_rx #(
    parameter int unsigned PREAMBLE_MIN  = 12,
    parameter logic [47:0] MAC_FILTER    = 48'hFF_FF_FF_FF_FF_FF,
    parameter int unsigned PAYLOAD_BYTES = 38
) (
    input  logic        eth_clk,
    input  logic        eth_rstn,
    input  logic        eth_crsdv,
    input  logic [1:0]  eth_rxd,
    output logic [10:0] opp_x,
    output logic [10:0] opp_y,
    output logic [8:0]  opp_dir,
    output logic [2:0]  opp_stat,
    output logic        opp_rst,
    output logic        opp_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_FCS      = 3'd4,
        ST_COMMIT   = 3'd5,
        ST_DRAIN    = 3'd6
    } state_t;

    localparam logic [7:0] DEST_LAST  = 8'd5;
    localparam logic [7:0] HDR_LAST   = 8'd13;
    localparam logic [7:0] FCS_LAST   = 8'd3;
    localparam logic [7:0] GAME_BYTES = 8'd6;
    localparam logic [7:0] PAY_LAST   = 8'(PAYLOAD_BYTES - 1);

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  dib_cnt_r;
    logic [7:0]  byte_cnt_r;
    logic [5:0]  pre_cnt_r;
    logic [5:0]  byte_sr_r;
    logic [47:0] word_sr_r;
    logic [7:0]  cur_byte_s;
    logic        byte_done_s;
    logic        dest_ok_s;
    logic        crc_ok_s;
    logic        valid_s;
    logic        err_s;

    // The current dibit completes the byte; earlier dibits sit in byte_sr_r, oldest at [1:0].
    assign cur_byte_s  = {eth_rxd, byte_sr_r};
    assign byte_done_s = eth_crsdv && (dib_cnt_r == 2'd3);
    assign dest_ok_s   = ({word_sr_r[39:0], cur_byte_s} == MAC_FILTER);

`ifdef RX_FCS_CHECK_EN
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[31] ^ d[i]) begin
                c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [31:0] crc_r;

    // Running CRC over dest..FCS, seeded while the preamble is being counted.
    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) begin
            crc_r <= 32'h0000_0000;
        end else if (state_r == ST_PREAMBLE) begin
            crc_r <= 32'hFFFF_FFFF;
        end else if (eth_crsdv && ((state_r == ST_HEADER) || (state_r == ST_PAYLOAD) ||
                                   (state_r == ST_FCS))) begin
            crc_r <= crc32_dibit(crc_r, eth_rxd);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc_ok_s = (crc_r == 32'hC704_DD7B);
`else
    assign crc_ok_s = 1'b1;
`endif

    // State register.
    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_s = state_r;
        valid_s = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (eth_crsdv) begin
                    state_s = (eth_rxd == 2'b01) ? ST_PREAMBLE : ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!eth_crsdv) begin
                    state_s = ST_IDLE;
                end else if (eth_rxd == 2'b01) begin
                    state_s = ST_PREAMBLE;
                end else if ((eth_rxd == 2'b11) && (32'(pre_cnt_r) >= PREAMBLE_MIN)) begin
                    state_s = ST_HEADER;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_HEADER: begin
                if (!eth_crsdv) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else if (byte_done_s && (byte_cnt_r == DEST_LAST) && !dest_ok_s) begin
                    state_s = ST_DRAIN;
                    err_s   = 1'b1;
                end else if (byte_done_s && (byte_cnt_r == HDR_LAST)) begin
                    state_s = ST_PAYLOAD;
                end else begin
                    state_s = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (!eth_crsdv) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else if (byte_done_s && (byte_cnt_r == PAY_LAST)) begin
                    state_s = ST_FCS;
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_FCS: begin
                if (!eth_crsdv) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else if (byte_done_s && (byte_cnt_r == FCS_LAST)) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_FCS;
                end
            end
            ST_COMMIT: begin
                state_s = ST_DRAIN;
                if (crc_ok_s) begin
                    valid_s = 1'b1;
                end else begin
                    err_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!eth_crsdv) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Dibit/byte assembly, preamble counting and the header/game-word shift register.
    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) begin
            dib_cnt_r  <= 2'd0;
            byte_cnt_r <= 8'd0;
            pre_cnt_r  <= 6'd0;
            byte_sr_r  <= 6'd0;
            word_sr_r  <= 48'd0;
        end else begin
            if (state_s != state_r) begin
                dib_cnt_r  <= 2'd0;
                byte_cnt_r <= 8'd0;
            end else if (eth_crsdv) begin
                dib_cnt_r  <= dib_cnt_r + 2'd1;
                byte_cnt_r <= byte_done_s ? (byte_cnt_r + 8'd1) : byte_cnt_r;
            end else begin
                dib_cnt_r  <= dib_cnt_r;
                byte_cnt_r <= byte_cnt_r;
            end

            if (eth_crsdv) begin
                byte_sr_r <= {eth_rxd, byte_sr_r[5:2]};
            end else begin
                byte_sr_r <= byte_sr_r;
            end

            if (state_r == ST_IDLE) begin
                pre_cnt_r <= 6'd1;
            end else if ((state_r == ST_PREAMBLE) && eth_crsdv && (eth_rxd == 2'b01) &&
                         (pre_cnt_r != 6'd63)) begin
                pre_cnt_r <= pre_cnt_r + 6'd1;
            end else begin
                pre_cnt_r <= pre_cnt_r;
            end

            if (byte_done_s && ((state_r == ST_HEADER) ||
                                ((state_r == ST_PAYLOAD) && (byte_cnt_r < GAME_BYTES)))) begin
                word_sr_r <= {word_sr_r[39:0], cur_byte_s};
            end else begin
                word_sr_r <= word_sr_r;
            end
        end
    end

    // Registered outputs: opponent state, strobes and accepted-frame counter.
    always_ff @(posedge eth_clk or negedge eth_rstn) begin
        if (!eth_rstn) begin
            opp_x     <= 11'd0;
            opp_y     <= 11'd0;
            opp_dir   <= 9'd0;
            opp_stat  <= 3'd0;
            opp_rst   <= 1'b0;
            opp_valid <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            opp_valid <= valid_s;
            frame_err <= err_s;
            if (valid_s) begin
                opp_x     <= word_sr_r[47:37];
                opp_y     <= word_sr_r[35:25];
                opp_dir   <= word_sr_r[23:15];
                opp_stat  <= word_sr_r[11:9];
                opp_rst   <= word_sr_r[7];
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                opp_x     <= opp_x;
                opp_y     <= opp_y;
                opp_dir   <= opp_dir;
                opp_stat  <= opp_stat;
                opp_rst   <= opp_rst;
                frame_cnt <= frame_cnt;
            end
        end
    end

endmodule
